// File: rtl/rom_dnload_seq.sv
// ---------------------------------------------------------------------------
// rom_dnload_seq
//
// Splits the HPS ioctl ROM download stream into the three ROM regions of the
// canyon_bomber core and owns the core's active-low reset.
//
// The core reset is held while a download is running or while the user
// requests a reset. It is released HOLD_CYC cycles after both have ended.
//
// Optional feature (macro DNLOAD_CSUM_EN):
//   Adds csum_o, an 8-bit modulo-256 sum of every byte that produced a
//   region strobe in the current download.
//
// Ports:
//   clk_sys      in   system clock; all logic is on the rising edge
//   Reset_I      in   asynchronous active-low reset
//   dl_active_i  in   ioctl_download level
//   dl_wr_i      in   ioctl_wr byte strobe (one cycle wide)
//   dl_addr_i    in   ioctl byte address [ADDR_W]
//   dl_data_i    in   ioctl byte [8]
//   usr_rst_i    in   user reset request, active-high
//   rom_wr_o     out  one-hot region write strobe [3], one cycle wide
//   rom_addr_o   out  address local to the strobed region [ADDR_W]
//   rom_data_o   out  byte that goes with rom_wr_o [8]
//   core_rst_n_o out  active-low core reset (registered)
//   loaded_o     out  a download has completed since Reset_I
//   ovf_o        out  sticky: a byte was addressed past the last region
//   csum_o       out  [8] byte checksum (only with DNLOAD_CSUM_EN)
//   dbg_state_o  out  current FSM state (HOLD=0, RUN=1, LOAD=2)
//
// Handshake: dl_wr_i is a valid-only strobe with no ready/backpressure.
// Every dl_wr_i accepted in LOAD yields either one rom_wr_o pulse on the
// following cycle or sets ovf_o. Accepting one byte per cycle is supported.
// ---------------------------------------------------------------------------
module rom_dnload_seq #(
    parameter int ADDR_W   = 17,
    parameter int R0_SIZE  = 2048,
    parameter int R1_SIZE  = 512,
    parameter int R2_SIZE  = 256,
    parameter int HOLD_CYC = 16
) (
    input  logic              clk_sys,
    input  logic              Reset_I,
    input  logic              dl_active_i,
    input  logic              dl_wr_i,
    input  logic [ADDR_W-1:0] dl_addr_i,
    input  logic [7:0]        dl_data_i,
    input  logic              usr_rst_i,
    output logic [2:0]        rom_wr_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [7:0]        rom_data_o,
    output logic              core_rst_n_o,
    output logic              loaded_o,
    output logic              ovf_o,
`ifdef DNLOAD_CSUM_EN
    output logic [7:0]        csum_o,
`endif
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(HOLD_CYC + 1);

    // Region boundaries at ADDR_W bits. The compares below are unsigned.
    localparam logic [ADDR_W-1:0] END0 = ADDR_W'(R0_SIZE);
    localparam logic [ADDR_W-1:0] END1 = ADDR_W'(R0_SIZE + R1_SIZE);
    localparam logic [ADDR_W-1:0] END2 = ADDR_W'(R0_SIZE + R1_SIZE + R2_SIZE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_CYC - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    logic [2:0]        dec_wr;
    logic [ADDR_W-1:0] dec_addr;
    logic              dec_ovf;

    assign dbg_state_o = state;

    // Region decode. Each subtraction is only taken when the address is
    // already at or above the subtracted base, so it never wraps.
    always_comb begin
        dec_wr   = 3'b000;
        dec_addr = dl_addr_i;
        dec_ovf  = 1'b0;
        if (dl_addr_i < END0) begin
            dec_wr   = 3'b001;
            dec_addr = dl_addr_i;
        end else if (dl_addr_i < END1) begin
            dec_wr   = 3'b010;
            dec_addr = dl_addr_i - END0;
        end else if (dl_addr_i < END2) begin
            dec_wr   = 3'b100;
            dec_addr = dl_addr_i - END1;
        end else begin
            dec_ovf  = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            state        <= HOLD;
            cnt          <= '0;
            core_rst_n_o <= 1'b0;
            loaded_o     <= 1'b0;
            ovf_o        <= 1'b0;
            rom_wr_o     <= 3'b000;
            rom_addr_o   <= '0;
            rom_data_o   <= 8'h00;
`ifdef DNLOAD_CSUM_EN
            csum_o       <= 8'h00;
`endif
        end else begin
            // The strobe is a single-cycle pulse. Address and data are held.
            rom_wr_o <= 3'b000;

            case (state)
                HOLD: begin
                    if (dl_active_i) begin
                        // Any partial hold count is discarded.
                        state <= LOAD;
                        cnt   <= '0;
                        ovf_o <= 1'b0;
`ifdef DNLOAD_CSUM_EN
                        csum_o <= 8'h00;
`endif
                    end else if (usr_rst_i) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= RUN;
                        core_rst_n_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RUN: begin
                    // A download wins over a user reset.
                    if (dl_active_i) begin
                        state        <= LOAD;
                        core_rst_n_o <= 1'b0;
                        ovf_o        <= 1'b0;
`ifdef DNLOAD_CSUM_EN
                        csum_o       <= 8'h00;
`endif
                    end else if (usr_rst_i) begin
                        state        <= HOLD;
                        cnt          <= '0;
                        core_rst_n_o <= 1'b0;
                    end
                end

                LOAD: begin
                    if (!dl_active_i) begin
                        state    <= HOLD;
                        cnt      <= '0;
                        loaded_o <= 1'b1;
                    end else if (dl_wr_i) begin
                        if (dec_ovf) begin
                            ovf_o <= 1'b1;
                        end else begin
                            rom_wr_o   <= dec_wr;
                            rom_addr_o <= dec_addr;
                            rom_data_o <= dl_data_i;
`ifdef DNLOAD_CSUM_EN
                            csum_o     <= csum_o + dl_data_i;
`endif
                        end
                    end
                end

                default: begin
                    state        <= HOLD;
                    cnt          <= '0;
                    core_rst_n_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_dnload_seq.sv
module tb_rom_dnload_seq;

    localparam int ADDR_W = 17;
    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    logic              clk_sys;
    logic              Reset_I;
    logic              dl_active_i;
    logic              dl_wr_i;
    logic [ADDR_W-1:0] dl_addr_i;
    logic [7:0]        dl_data_i;
    logic              usr_rst_i;
    logic [2:0]        rom_wr_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [7:0]        rom_data_o;
    logic              core_rst_n_o;
    logic              loaded_o;
    logic              ovf_o;
    logic [1:0]        dbg_state_o;
`ifdef DNLOAD_CSUM_EN
    logic [7:0]        csum_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // expected {rom_wr, rom_addr, rom_data} per driven byte
    logic [27:0] exp_q[$];

    rom_dnload_seq dut (
        .clk_sys      (clk_sys),
        .Reset_I      (Reset_I),
        .dl_active_i  (dl_active_i),
        .dl_wr_i      (dl_wr_i),
        .dl_addr_i    (dl_addr_i),
        .dl_data_i    (dl_data_i),
        .usr_rst_i    (usr_rst_i),
        .rom_wr_o     (rom_wr_o),
        .rom_addr_o   (rom_addr_o),
        .rom_data_o   (rom_data_o),
        .core_rst_n_o (core_rst_n_o),
        .loaded_o     (loaded_o),
        .ovf_o        (ovf_o),
`ifdef DNLOAD_CSUM_EN
        .csum_o       (csum_o),
`endif
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Drives one byte at a falling edge and checks the registered result
    // at the next falling edge (one rising edge in between).
    task automatic write_byte(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                              input logic [2:0] e_wr, input logic [ADDR_W-1:0] e_addr,
                              input logic [7:0] e_data);
        logic [27:0] e;
        exp_q.push_back({e_wr, e_addr, e_data});
        dl_wr_i   = 1'b1;
        dl_addr_i = a;
        dl_data_i = d;
        @(negedge clk_sys);
        dl_wr_i = 1'b0;
        e = exp_q.pop_front();
        check({tag, ".wr"},   {29'd0, rom_wr_o},   {29'd0, e[27:25]});
        check({tag, ".addr"}, {15'd0, rom_addr_o}, {15'd0, e[24:8]});
        check({tag, ".data"}, {24'd0, rom_data_o}, {24'd0, e[7:0]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_sys);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset_I     = 1'b0;
        dl_active_i = 1'b0;
        dl_wr_i     = 1'b0;
        dl_addr_i   = '0;
        dl_data_i   = 8'h00;
        usr_rst_i   = 1'b0;

        // 1: reset values and hold release timing
        idle(5);
        check("rst.wr",     {29'd0, rom_wr_o}, 32'd0);
        check("rst.addr",   {15'd0, rom_addr_o}, 32'd0);
        check("rst.core",   {31'd0, core_rst_n_o}, 32'd0);
        check("rst.loaded", {31'd0, loaded_o}, 32'd0);
        check("rst.ovf",    {31'd0, ovf_o}, 32'd0);
        check("rst.state",  {30'd0, dbg_state_o}, {30'd0, ST_HOLD});
        Reset_I = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk_sys);
            if (e == 15) check("hold.e15", {31'd0, core_rst_n_o}, 32'd0);
            if (e == 16) check("hold.e16", {31'd0, core_rst_n_o}, 32'd1);
        end
        check("hold.loaded", {31'd0, loaded_o}, 32'd0);
        check("hold.state",  {30'd0, dbg_state_o}, {30'd0, ST_RUN});

        // 2: download with boundary addresses, back-to-back
        dl_active_i = 1'b1;
        @(negedge clk_sys);
        check("load.state", {30'd0, dbg_state_o}, {30'd0, ST_LOAD});
        check("load.core",  {31'd0, core_rst_n_o}, 32'd0);
        write_byte("b7ff", 17'h007FF, 8'h11, 3'b001, 17'h007FF, 8'h11);
        write_byte("b800", 17'h00800, 8'h22, 3'b010, 17'h00000, 8'h22);
        write_byte("b9ff", 17'h009FF, 8'h33, 3'b010, 17'h001FF, 8'h33);
        write_byte("ba00", 17'h00A00, 8'h44, 3'b100, 17'h00000, 8'h44);
        write_byte("baff", 17'h00AFF, 8'h55, 3'b100, 17'h000FF, 8'h55);
        // strobe is one cycle wide, address and data hold
        @(negedge clk_sys);
        check("idle.wr",   {29'd0, rom_wr_o}, 32'd0);
        check("idle.addr", {15'd0, rom_addr_o}, 32'h0FF);
        check("idle.data", {24'd0, rom_data_o}, 32'h55);

        // 3: overflow byte
        check("ovf.pre", {31'd0, ovf_o}, 32'd0);
        write_byte("bb00", 17'h00B00, 8'h66, 3'b000, 17'h000FF, 8'h55);
        check("ovf.set", {31'd0, ovf_o}, 32'd1);

        // 4: end of download, user reset restarts the hold count
        dl_active_i = 1'b0;
        @(negedge clk_sys);
        check("end.loaded", {31'd0, loaded_o}, 32'd1);
        check("end.core",   {31'd0, core_rst_n_o}, 32'd0);
        check("end.ovf",    {31'd0, ovf_o}, 32'd1);
        for (int e = 1; e <= 24; e++) begin
            usr_rst_i = (e == 8);
            @(negedge clk_sys);
            if (e == 16) check("usr.e16", {31'd0, core_rst_n_o}, 32'd0);
            if (e == 23) check("usr.e23", {31'd0, core_rst_n_o}, 32'd0);
            if (e == 24) check("usr.e24", {31'd0, core_rst_n_o}, 32'd1);
        end
        usr_rst_i = 1'b0;

        // 3 (cont): next download clears ovf on entry
        dl_active_i = 1'b1;
        @(negedge clk_sys);
        check("reload.ovf",   {31'd0, ovf_o}, 32'd0);
        check("reload.state", {30'd0, dbg_state_o}, {30'd0, ST_LOAD});

        // 5: async reset mid-stream
        write_byte("b005", 17'h00005, 8'h3C, 3'b001, 17'h00005, 8'h3C);
        dl_wr_i   = 1'b1;
        dl_addr_i = 17'h00010;
        dl_data_i = 8'h99;
        #2 Reset_I = 1'b0;
        #1;
        check("arst.wr",     {29'd0, rom_wr_o}, 32'd0);
        check("arst.addr",   {15'd0, rom_addr_o}, 32'd0);
        check("arst.data",   {24'd0, rom_data_o}, 32'd0);
        check("arst.loaded", {31'd0, loaded_o}, 32'd0);
        check("arst.state",  {30'd0, dbg_state_o}, {30'd0, ST_HOLD});
        @(negedge clk_sys);
        dl_wr_i = 1'b0;
        check("arst.hold", {29'd0, rom_wr_o}, 32'd0);
        Reset_I = 1'b1;
        @(negedge clk_sys);
        check("rel.state", {30'd0, dbg_state_o}, {30'd0, ST_LOAD});
        write_byte("b900", 17'h00900, 8'h77, 3'b010, 17'h00100, 8'h77);
        // writes with dl_active_i low never strobe
        dl_active_i = 1'b0;
        write_byte("off1", 17'h00001, 8'h12, 3'b000, 17'h00100, 8'h77);
        write_byte("off2", 17'h00002, 8'h13, 3'b000, 17'h00100, 8'h77);
        // write on the cycle dl_active_i rises is ignored
        dl_active_i = 1'b1;
        write_byte("rise", 17'h00003, 8'h14, 3'b000, 17'h00100, 8'h77);

`ifdef DNLOAD_CSUM_EN
        // 6: checksum
        check("cs.clr", {24'd0, csum_o}, 32'd0);
        write_byte("cs0", 17'h00000, 8'hF0, 3'b001, 17'h00000, 8'hF0);
        write_byte("cs1", 17'h00001, 8'h20, 3'b001, 17'h00001, 8'h20);
        write_byte("cs2", 17'h00002, 8'h05, 3'b001, 17'h00002, 8'h05);
        check("cs.sum", {24'd0, csum_o}, 32'h15);
        write_byte("csov", 17'h00B00, 8'hAA, 3'b000, 17'h00002, 8'h05);
        check("cs.ovf", {24'd0, csum_o}, 32'h15);
`endif

        dl_active_i = 1'b0;
        idle(2);
        check("fin.loaded", {31'd0, loaded_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
